// File: rtl/sw_alloc_rr_if.sv
// Switch allocator port bundle: per-input request/flit, per-output registered flit and grant.
// Index order everywhere is L, W, E, S.
interface sw_alloc_rr_if #(
    parameter int DATASIZE = 40
);
    logic                L_valid_in, W_valid_in, E_valid_in, S_valid_in;
    logic [3:0]          L_label, W_label, E_label, S_label;
    logic [DATASIZE-1:0] L_data_in, W_data_in, E_data_in, S_data_in;
    logic                W_full, E_full, S_full;
    logic                L_ready, W_ready, E_ready, S_ready;
    logic [DATASIZE-1:0] L_data_out, W_data_out, E_data_out, S_data_out;
    logic                L_valid_out, W_valid_out, E_valid_out, S_valid_out;
    logic                err_label;

    modport slave (
        input  L_valid_in, W_valid_in, E_valid_in, S_valid_in,
        input  L_label, W_label, E_label, S_label,
        input  L_data_in, W_data_in, E_data_in, S_data_in,
        input  W_full, E_full, S_full,
        output L_ready, W_ready, E_ready, S_ready,
        output L_data_out, W_data_out, E_data_out, S_data_out,
        output L_valid_out, W_valid_out, E_valid_out, S_valid_out,
        output err_label
    );

    modport master (
        output L_valid_in, W_valid_in, E_valid_in, S_valid_in,
        output L_label, W_label, E_label, S_label,
        output L_data_in, W_data_in, E_data_in, S_data_in,
        output W_full, E_full, S_full,
        input  L_ready, W_ready, E_ready, S_ready,
        input  L_data_out, W_data_out, E_data_out, S_data_out,
        input  L_valid_out, W_valid_out, E_valid_out, S_valid_out,
        input  err_label
    );
endinterface

// File: rtl/sw_alloc_rr.sv
// 4x4 round-robin switch allocator: combinational grant/ready, flit registered on the grant edge.
// Latency 1 cycle ready->valid_out; a full output issues no grant and its requesters see ready=0.
module sw_alloc_rr #(
    parameter int DATASIZE = 40
) (
    input  logic            clk,
    input  logic            rst,
    sw_alloc_rr_if.slave    bus
);
    logic [3:0]          vin;
    logic [3:0]          lab     [4];
    logic [DATASIZE-1:0] din     [4];
    logic [3:0]          blk;
    logic [3:0]          legal;
    logic [3:0]          illegal;
    logic [3:0]          req     [4];
    logic [3:0]          gnt     [4];
    logic [3:0]          ready;

    logic [1:0]          ptr_q   [4];
    logic [1:0]          ptr_d   [4];
    logic [DATASIZE-1:0] data_q  [4];
    logic [DATASIZE-1:0] data_d  [4];
    logic [3:0]          valid_q;
    logic [3:0]          valid_d;
    logic                err_q;
    logic                err_d;

    assign vin    = {bus.S_valid_in, bus.E_valid_in, bus.W_valid_in, bus.L_valid_in};
    assign lab[0] = bus.L_label;
    assign lab[1] = bus.W_label;
    assign lab[2] = bus.E_label;
    assign lab[3] = bus.S_label;
    assign din[0] = bus.L_data_in;
    assign din[1] = bus.W_data_in;
    assign din[2] = bus.E_data_in;
    assign din[3] = bus.S_data_in;
    // The local port always drains, so it is never blocked.
    assign blk    = {bus.S_full, bus.E_full, bus.W_full, 1'b0};

    always_comb begin
        legal   = '0;
        illegal = '0;
        for (int o = 0; o < 4; o++) req[o] = '0;
        for (int i = 0; i < 4; i++) begin
            legal[i]   = vin[i] && $onehot(lab[i]) && !lab[i][i];
            illegal[i] = vin[i] && !legal[i];
            for (int o = 0; o < 4; o++) req[o][i] = legal[i] && lab[i][o];
        end
    end

    always_comb begin
        logic       found;
        logic [1:0] idx;
        ready = '0;
        found = 1'b0;
        idx   = '0;
        for (int o = 0; o < 4; o++) begin
            gnt[o]   = '0;
            ptr_d[o] = ptr_q[o];
            found    = 1'b0;
            // Grants are suppressed while in reset so ready reads 0 immediately.
            if (!blk[o] && !rst) begin
                for (int k = 0; k < 4; k++) begin
                    idx = ptr_q[o] + 2'(k);
                    if (!found && req[o][idx]) begin
                        found       = 1'b1;
                        gnt[o][idx] = 1'b1;
                        ptr_d[o]    = idx + 2'd1;
                    end
                end
            end
            ready = ready | gnt[o];
        end
    end

    always_comb begin
        for (int o = 0; o < 4; o++) begin
            valid_d[o] = |gnt[o];
            data_d[o]  = data_q[o];
            for (int i = 0; i < 4; i++) begin
                if (gnt[o][i]) data_d[o] = din[i];
            end
        end
        err_d = err_q | (|illegal);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int o = 0; o < 4; o++) begin
                ptr_q[o]  <= '0;
                data_q[o] <= '0;
            end
            valid_q <= '0;
            err_q   <= 1'b0;
        end else begin
            for (int o = 0; o < 4; o++) begin
                ptr_q[o]  <= ptr_d[o];
                data_q[o] <= data_d[o];
            end
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign bus.L_ready     = ready[0];
    assign bus.W_ready     = ready[1];
    assign bus.E_ready     = ready[2];
    assign bus.S_ready     = ready[3];
    assign bus.L_data_out  = data_q[0];
    assign bus.W_data_out  = data_q[1];
    assign bus.E_data_out  = data_q[2];
    assign bus.S_data_out  = data_q[3];
    assign bus.L_valid_out = valid_q[0];
    assign bus.W_valid_out = valid_q[1];
    assign bus.E_valid_out = valid_q[2];
    assign bus.S_valid_out = valid_q[3];
    assign bus.err_label   = err_q;
endmodule

// File: tb/tb_sw_alloc_rr.sv
// Directed bench for sw_alloc_rr: per-cycle expected grants are pushed to a scoreboard
// when stimulus is driven and popped against the registered outputs after the edge.
module tb_sw_alloc_rr;
    localparam int DS = 40;

    typedef struct packed {
        logic [3:0]         vld;
        logic [3:0][DS-1:0] dat;
    } exp_t;

    logic clk;
    logic rst;
    sw_alloc_rr_if #(.DATASIZE(DS)) bus ();

    sw_alloc_rr #(.DATASIZE(DS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [3:0]    vin;
    logic [3:0]    lab  [4];
    logic [DS-1:0] din  [4];
    logic [3:0]    full;

    assign bus.L_valid_in = vin[0];
    assign bus.W_valid_in = vin[1];
    assign bus.E_valid_in = vin[2];
    assign bus.S_valid_in = vin[3];
    assign bus.L_label    = lab[0];
    assign bus.W_label    = lab[1];
    assign bus.E_label    = lab[2];
    assign bus.S_label    = lab[3];
    assign bus.L_data_in  = din[0];
    assign bus.W_data_in  = din[1];
    assign bus.E_data_in  = din[2];
    assign bus.S_data_in  = din[3];
    assign bus.W_full     = full[1];
    assign bus.E_full     = full[2];
    assign bus.S_full     = full[3];

    wire [3:0]    rdy_v = {bus.S_ready, bus.E_ready, bus.W_ready, bus.L_ready};
    wire [3:0]    vo_v  = {bus.S_valid_out, bus.E_valid_out, bus.W_valid_out, bus.L_valid_out};
    wire [DS-1:0] dout [4];
    assign dout[0] = bus.L_data_out;
    assign dout[1] = bus.W_data_out;
    assign dout[2] = bus.E_data_out;
    assign dout[3] = bus.S_data_out;

    exp_t          sb[$];
    logic [DS-1:0] exp_last [4];
    logic          exp_err;
    int            n_cmp;
    int            n_bad;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input int i, input logic [3:0] l);
        logic [63:0] t;
        t      = {$urandom(), $urandom()};
        vin[i] = 1'b1;
        lab[i] = l;
        din[i] = t[DS-1:0];
    endtask

    task automatic clr();
        vin  = '0;
        full = '0;
        for (int i = 0; i < 4; i++) lab[i] = '0;
    endtask

    // Called at a negedge with inputs set; wN = winning input for output N, -1 for none.
    task automatic step(input string tag, input int w0, input int w1, input int w2, input int w3);
        int         w [4];
        logic [3:0] er;
        exp_t       e;
        w  = '{w0, w1, w2, w3};
        er = '0;
        e  = '0;
        for (int o = 0; o < 4; o++) begin
            if (w[o] >= 0) begin
                er[w[o]]  = 1'b1;
                e.vld[o]  = 1'b1;
                e.dat[o]  = din[w[o]];
            end
        end
        for (int i = 0; i < 4; i++)
            if (vin[i] && ($countones(lab[i]) != 1 || lab[i][i])) exp_err = 1'b1;
        sb.push_back(e);
        #2;
        chk({tag, " ready"}, 64'(rdy_v), 64'(er));
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({tag, " valid_out"}, 64'(vo_v), 64'(e.vld));
        for (int o = 0; o < 4; o++) begin
            if (e.vld[o]) exp_last[o] = e.dat[o];
            chk($sformatf("%s data_out[%0d]", tag, o), 64'(dout[o]), 64'(exp_last[o]));
        end
        chk({tag, " err_label"}, 64'(bus.err_label), 64'(exp_err));
        @(negedge clk);
    endtask

    initial begin
        int cl;
        int cs;
        n_cmp   = 0;
        n_bad   = 0;
        exp_err = 1'b0;
        for (int o = 0; o < 4; o++) exp_last[o] = '0;
        rst = 1'b1;
        clr();
        // Legal requests present during reset must not produce ready.
        set_in(0, 4'b0100);
        set_in(1, 4'b1000);
        set_in(2, 4'b0010);
        set_in(3, 4'b0001);
        #3;
        chk("rst ready", 64'(rdy_v), 64'h0);
        chk("rst valid_out", 64'(vo_v), 64'h0);
        for (int o = 0; o < 4; o++) chk($sformatf("rst data_out[%0d]", o), 64'(dout[o]), 64'h0);
        chk("rst err_label", 64'(bus.err_label), 64'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        clr();

        // Case 1: L, W, S contend for E.
        set_in(0, 4'b0100); set_in(1, 4'b0100); set_in(3, 4'b0100);
        step("c1 g1", -1, -1, 0, -1);
        set_in(0, 4'b0100); set_in(1, 4'b0100); set_in(3, 4'b0100);
        step("c1 g2", -1, -1, 1, -1);
        set_in(0, 4'b0100); set_in(1, 4'b0100); set_in(3, 4'b0100);
        step("c1 g3", -1, -1, 3, -1);
        clr();
        step("c1 idle", -1, -1, -1, -1);

        // Case 2: W->S blocked by S_full for 4 cycles.
        set_in(1, 4'b1000);
        full[3] = 1'b1;
        for (int c = 0; c < 4; c++) step($sformatf("c2 blk%0d", c), -1, -1, -1, -1);
        full[3] = 1'b0;
        step("c2 grant", -1, -1, -1, 1);
        clr();
        // ptr_S is now 2: a blocked pair L,W must leave it there, so L wins on release.
        set_in(0, 4'b1000); set_in(1, 4'b1000);
        full[3] = 1'b1;
        step("c2b blk0", -1, -1, -1, -1);
        step("c2b blk1", -1, -1, -1, -1);
        full[3] = 1'b0;
        step("c2b grant", -1, -1, -1, 0);
        clr();

        // Case 3: four concurrent transfers.
        set_in(0, 4'b0100); set_in(2, 4'b0010); set_in(1, 4'b1000); set_in(3, 4'b0001);
        step("c3 par", 3, 2, 0, 1);
        clr();

        // Case 4: multi-bit label then U-turn on E.
        set_in(2, 4'b0110);
        step("c4 multi", -1, -1, -1, -1);
        set_in(2, 4'b0100);
        step("c4 uturn", -1, -1, -1, -1);
        clr();
        step("c4 sticky", -1, -1, -1, -1);

        // Case 6: async reset while every output holds a flit.
        set_in(0, 4'b0100); set_in(2, 4'b0010); set_in(1, 4'b1000); set_in(3, 4'b0001);
        step("c6 par", 3, 2, 0, 1);
        rst = 1'b1;
        #1;
        chk("c6 async valid_out", 64'(vo_v), 64'h0);
        chk("c6 async ready", 64'(rdy_v), 64'h0);
        for (int o = 0; o < 4; o++) chk($sformatf("c6 async data_out[%0d]", o), 64'(dout[o]), 64'h0);
        chk("c6 async err_label", 64'(bus.err_label), 64'h0);
        for (int o = 0; o < 4; o++) exp_last[o] = '0;
        exp_err = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        clr();

        // Case 5: L and S share W; fresh pointer after reset starts at L.
        cl = 0;
        cs = 0;
        for (int c = 0; c < 8; c++) begin
            set_in(0, 4'b0010); set_in(3, 4'b0010);
            #1;
            if (bus.L_ready) cl++;
            if (bus.S_ready) cs++;
            step($sformatf("c5 g%0d", c), -1, (c % 2 == 0) ? 0 : 3, -1, -1);
        end
        chk("c5 grants L", 64'(cl), 64'd4);
        chk("c5 grants S", 64'(cs), 64'd4);
        clr();
        step("c5 idle", -1, -1, -1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sw_alloc_rr.md
SW_ALLOC_RR -- requirements
Module: sw_alloc_rr

Interface
REQ-001 Parameter DATASIZE, default 40, SHALL set the flit width (src 4b, dst 4b, timestamp 8b, data 22b, type 2b).
REQ-002 Port indices SHALL be fixed: 0 = L, 1 = W, 2 = E, 3 = S; label bit k selects output port k.
REQ-003 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 X_valid_in  input  1  (X = L, W, E, S): input X holds a routed flit.
REQ-006 X_label  input  4  one-hot requested output for input X.
REQ-007 X_data_in  input  DATASIZE  flit from input X.
REQ-008 W_full, E_full, S_full  input  1  each: downstream buffer full; the L output is never blocked.
REQ-009 X_ready  output  1  combinational grant; the flit is consumed this cycle.
REQ-010 X_data_out  output  DATASIZE  registered flit for output X.
REQ-011 X_valid_out  output  1  registered; X_data_out is valid.
REQ-012 err_label  output  1  registered, sticky; an illegal label was seen.

Function
REQ-013 Input i SHALL request output o when i_valid_in=1, label is one-hot, label[o]=1, and o != i (no U-turn).
REQ-014 A label that is zero or multi-bit, or a U-turn request, SHALL NOT request, SHALL NOT assert ready, and SHALL set err_label on the next edge.
REQ-015 Output o SHALL be eligible only when its full input is 0 in the same cycle.
REQ-016 Each eligible output SHALL grant exactly one requester per cycle, chosen round-robin from ptr_o.
REQ-017 Round-robin search SHALL scan ptr_o, ptr_o+1, ... mod 4; the first requester found wins.
REQ-018 ptr_o (2 bits, one per output) SHALL load winner+1 mod 4 after a grant and hold when there is no grant.
REQ-019 X_ready SHALL be 1 in the cycle input X wins any output, else 0; at most one grant per input, since a label is one-hot.
REQ-020 On a grant, the next edge SHALL register the winner's data into o_data_out and set o_valid_out=1.
REQ-021 With no grant, o_valid_out SHALL be 0 on the next edge, and o_data_out SHALL hold its value.
REQ-022 Latency SHALL be 1 cycle from ready to valid_out; throughput SHALL be 1 flit per output per cycle.
REQ-023 Different outputs SHALL arbitrate independently in the same cycle, allowing 4 concurrent transfers.
REQ-024 If full rises while the output is idle, no grant SHALL issue; the pointer SHALL hold and requesters SHALL wait with ready=0.
REQ-025 A flit already registered SHALL be presented regardless of a full that arrives later; full only gates new grants.
REQ-026 Losing requesters SHALL keep valid and label stable; a request that changes without a grant SHALL be treated as a new request, with no memory.
REQ-027 No combinational path SHALL run from X_valid_out to X_ready; the path from full to ready is combinational by design.

Reset
REQ-028 While rst=1, all valid_out SHALL be 0, all data_out 0, every ptr_o 0, err_label 0, and all ready outputs 0.
REQ-029 Assertion of rst SHALL take effect immediately without clk; deassertion SHALL be synchronized by the integrator.
REQ-030 Reset mid-transfer SHALL drop any registered flit; an input whose ready was high in that cycle SHALL not be replayed.

Verification
REQ-031 Case 1, contention on E: L, W and S all request E (label 4'b0100) for 3 cycles, E_full=0, after reset.
  - Grants SHALL go to L, then W, then S.
  - E_valid_out SHALL be high on cycles 2, 3 and 4, with the matching data.
REQ-032 Case 2, backpressure: W requests S (4'b1000) with S_full=1 for 4 cycles, then S_full=0.
  - W_ready SHALL stay 0 for 4 cycles, then go to 1 for one cycle.
  - S_valid_out SHALL rise one cycle later.
  - ptr_S SHALL stay 0 until that grant.
REQ-033 Case 3, parallel traffic: in one cycle L->E, E->W, W->S and S->L.
  - All four ready outputs SHALL be 1.
  - All four valid_out SHALL be 1 on the next edge, each carrying its source's data.
REQ-034 Case 4, illegal labels: E_label=4'b0110, then E_label=4'b0100 (E->E).
  - E_ready SHALL stay 0 for both.
  - err_label SHALL be 1 after the first edge and remain 1 until rst.
REQ-035 Case 5, fairness: L and S request W continuously for 8 cycles.
  - W grants SHALL alternate L, S, L, S, ...
  - Each input SHALL receive exactly 4 grants.
REQ-036 Case 6, reset mid-operation: assert rst asynchronously while valid_out=1 on all ports.
  - All valid_out SHALL fall to 0 before the next clk edge.
  - All pointers SHALL read 0 on the first grant after deassertion.
